// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, cache-miss freeze,
// branch flush and halt drain, with per-stage bookkeeping for stages 2..STAGES-1.
module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int RA_W   = 4,
    parameter int CNT_W  = 16,
    parameter int FS_W   = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rd1,
    input  logic [RA_W-1:0]   id_rd2,
    input  logic              id_rd1_en,
    input  logic              id_rd2_en,
    input  logic [RA_W-1:0]   id_wr_reg,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              id_is_halt,
    input  logic              br_taken,
    input  logic              i_rdy,
    input  logic              d_rdy,
    output logic [FS_W-1:0]   fwd_sel1,
    output logic [FS_W-1:0]   fwd_sel2,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              back_en,
    output logic              flush_front,
    output logic              halted,
    output logic [STAGES-3:0] stage_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [2:0]        dbg_state
);

    localparam int NB = STAGES - 2;

    typedef enum logic [2:0] {RUN, LU_STALL, MEM_WAIT, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] wr_reg;
        logic            wr_en;
        logic            is_load;
        logic            is_halt;
    } rec_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    state_t           eff;
    rec_t             rec_q [NB];
    rec_t             rec_d [NB];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FS_W-1:0]  sel1, sel2;
    logic             load_use, freeze, last_halt, older_halt;
    logic             bubble, kill2;

    function automatic logic hit(rec_t r, logic [RA_W-1:0] src, logic en);
        return en && r.valid && r.wr_en && (r.wr_reg == src) && (r.wr_reg != '0);
    endfunction

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int s = NB - 1; s >= 0; s--) begin
            if (hit(rec_q[s], id_rd1, id_rd1_en)) sel1 = FS_W'(s + 2);
            if (hit(rec_q[s], id_rd2, id_rd2_en)) sel2 = FS_W'(s + 2);
        end
    end

    assign fwd_sel1 = rst ? '0 : sel1;
    assign fwd_sel2 = rst ? '0 : sel2;

    assign load_use = id_valid && rec_q[0].is_load &&
                      ((sel1 == FS_W'(2)) || (sel2 == FS_W'(2)));
    assign freeze    = !i_rdy || !d_rdy;
    assign last_halt = rec_q[NB-1].valid && rec_q[NB-1].is_halt;

    // A halt in stage 3.. that survives a flush keeps the drain going.
    always_comb begin
        older_halt = 1'b0;
        for (int s = 1; s < NB - 1; s++) begin
            if (rec_q[s].valid && rec_q[s].is_halt) older_halt = 1'b1;
        end
    end

    assign eff = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        back_en     = 1'b1;
        flush_front = 1'b0;
        bubble      = 1'b0;
        kill2       = 1'b0;
        if (rst) begin
            state_d = RUN;
        end else if (eff == HALTED) begin
            {pc_en, if_id_en, id_ex_en, back_en} = 4'b0000;
            state_d = HALTED;
        end else if (freeze) begin
            {pc_en, if_id_en, id_ex_en, back_en} = 4'b0000;
            state_d = MEM_WAIT;
            ret_d   = eff;
        end else if (eff == DRAIN) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            bubble   = 1'b1;
            if (br_taken) begin
                flush_front = 1'b1;
                kill2       = 1'b1;
            end
            if (last_halt)                      state_d = HALTED;
            else if (br_taken && !older_halt)   state_d = RUN;
            else                                state_d = DRAIN;
        end else begin
            if (br_taken) begin
                flush_front = 1'b1;
                bubble      = 1'b1;
                kill2       = 1'b1;
                state_d     = RUN;
            end else if ((eff == RUN) && load_use) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                bubble   = 1'b1;
                state_d  = LU_STALL;
            end else if (id_valid && id_is_halt) begin
                state_d = DRAIN;
            end else begin
                state_d = RUN;
            end
        end
    end

    // The record leaving stage 2 on a taken branch is wrong-path work.
    always_comb begin
        rec_d = rec_q;
        if (back_en) begin
            rec_d[0] = bubble ? '0 : rec_t'{id_valid, id_wr_reg, id_wr_en, id_is_load, id_is_halt};
            for (int s = 1; s < NB; s++) rec_d[s] = rec_q[s-1];
            if (kill2) rec_d[1].valid = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!pc_en && (state_q != HALTED) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
            for (int s = 0; s < NB; s++) rec_q[s] <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            rec_q   <= rec_d;
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int s = 0; s < NB; s++) stage_valid[s] = rec_q[s].valid;
    end

    assign halted    = (state_q == HALTED);
    assign stall_cnt = cnt_q;
    assign dbg_state = state_q;

endmodule
